// File: rtl/value_stepper_pkg.sv
// ---------------------------------------------------------------------------
// value_stepper_pkg
//   Shared types and default constants for the value_stepper block.
//   - db_state_t : debouncer state encoding (LOW, RISE_WAIT, HIGH, FALL_WAIT)
//   - DEF_*      : default parameter values for a 100 MHz board clock
// ---------------------------------------------------------------------------
package value_stepper_pkg;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_RISE_WAIT = 2'd1,
        DB_HIGH      = 2'd2,
        DB_FALL_WAIT = 2'd3
    } db_state_t;

    localparam int unsigned DEF_WIDTH           = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms @ 100 MHz
    localparam int unsigned DEF_AUTO_PERIOD     = 50_000_000; // 0.5 s @ 100 MHz

endpackage

// File: rtl/value_stepper_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser followed by a four-state debounce FSM. A level is
//   accepted only after DEBOUNCE_CYCLES consecutive stable samples; any
//   bounce restarts the count. A single-cycle press pulse is emitted on an
//   accepted rising level only; release produces no pulse.
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  synchronous active-low reset
//   btn    in   1  raw asynchronous push-button, high = pressed
//   press  out  1  registered 1-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_debounce
    import value_stepper_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned   CNT_W   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;

    // Stage p0/p1: metastability synchroniser; stage p2: debounce FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            state   <= DB_LOW;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press   <= press_nxt;
        end
    end

    // The sample that moves the FSM out of a stable state counts as the first
    // stable sample, so the wait states start counting at one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            DB_LOW: begin
                if (sync_p1) begin
                    state_nxt = DB_RISE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_RISE_WAIT: begin
                if (!sync_p1) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DB_HIGH: begin
                if (!sync_p1) begin
                    state_nxt = DB_FALL_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_FALL_WAIT: begin
                if (sync_p1) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/value_stepper.sv
// ---------------------------------------------------------------------------
// value_stepper
//   Turns two push-buttons and a bank of switches into a registered value.
//   btn_step steps the value up or down (modulo 2**WIDTH) according to dir;
//   btn_load loads sw. A load and a step in the same cycle performs the load
//   only. value_upd pulses for one cycle whenever a new value is written,
//   even if it equals the old one.
//
//   Optional feature, macro AUTO_STEP_EN:
//     adds the auto_en port, the AUTO_PERIOD parameter and a prescaler that
//     steps the value every AUTO_PERIOD cycles while auto_en is high. A load
//     restarts the period; an auto tick coinciding with a manual step gives a
//     single step, and one coinciding with a load is dropped.
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   btn_step   in   1      raw push-button: step value
//   btn_load   in   1      raw push-button: load sw
//   dir        in   1      1 = count up, 0 = count down
//   sw         in   WIDTH  load value (quasi-static switches)
//   auto_en    in   1      auto-step enable (AUTO_STEP_EN builds only)
//   value      out  WIDTH  current value
//   value_upd  out  1      1-cycle pulse in the first cycle of a new value
// ---------------------------------------------------------------------------
module value_stepper
    import value_stepper_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
`ifdef AUTO_STEP_EN
    parameter int unsigned AUTO_PERIOD     = DEF_AUTO_PERIOD,
`endif
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_load,
    input  logic             dir,
    input  logic [WIDTH-1:0] sw,
`ifdef AUTO_STEP_EN
    input  logic             auto_en,
`endif
    output logic [WIDTH-1:0] value,
    output logic             value_upd
);

    localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);

    // Natural modulo wrap of the WIDTH-bit register gives 15->0 / 0->15.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic             up);
        return up ? (cur + VAL_ONE) : (cur - VAL_ONE);
    endfunction

    logic step_press;
    logic load_press;
    logic step_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .press (step_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_load),
        .press (load_press)
    );

`ifdef AUTO_STEP_EN
    localparam int unsigned      PRE_W   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(AUTO_PERIOD - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] presc;
    logic             auto_tick;

    assign auto_tick = auto_en && (presc == PRE_MAX);

    // Auto-step prescaler: held at zero while disabled, restarted by a load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!auto_en || load_press || auto_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_ONE;
        end
    end

    // OR-ing the sources merges a coincident manual and auto step into one.
    assign step_req = step_press | auto_tick;
`else
    assign step_req = step_press;
`endif

    // Value register: load has priority over any step request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value     <= '0;
            value_upd <= 1'b0;
        end else if (load_press) begin
            value     <= sw;
            value_upd <= 1'b1;
        end else if (step_req) begin
            value     <= step_value(value, dir);
            value_upd <= 1'b1;
        end else begin
            value_upd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_value_stepper.sv
// ---------------------------------------------------------------------------
// tb_value_stepper
//   Directed bench for value_stepper with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
//   Inputs are driven 1 time unit after a rising edge and outputs are sampled
//   at the same point, so a press driven after edge k updates value at k+8.
//   The auto-step sequence is compiled only when AUTO_STEP_EN is defined.
// ---------------------------------------------------------------------------
module tb_value_stepper;

    localparam int W  = 4;
    localparam int DB = 4;
`ifdef AUTO_STEP_EN
    localparam int AP = 8;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_step;
    logic         btn_load;
    logic         dir;
    logic [W-1:0] sw;
`ifdef AUTO_STEP_EN
    logic         auto_en;
`endif
    logic [W-1:0] value;
    logic         value_upd;

    always #5 clk = ~clk;

    value_stepper #(
        .WIDTH           (W),
`ifdef AUTO_STEP_EN
        .AUTO_PERIOD     (AP),
`endif
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_step  (btn_step),
        .btn_load  (btn_load),
        .dir       (dir),
        .sw        (sw),
`ifdef AUTO_STEP_EN
        .auto_en   (auto_en),
`endif
        .value     (value),
        .value_upd (value_upd)
    );

    int checks   = 0;
    int failures = 0;

    typedef enum int {OP_STEP, OP_LOAD, OP_BOTH} op_t;
    typedef struct {
        op_t          op;
        logic         dir;
        logic [W-1:0] sw;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Press the requested button(s), hold, release, and count update pulses.
    task automatic apply_vec(input int idx, input vec_t v);
        int upd_cnt;
        upd_cnt  = 0;
        dir      = v.dir;
        sw       = v.sw;
        btn_step = (v.op == OP_STEP || v.op == OP_BOTH);
        btn_load = (v.op == OP_LOAD || v.op == OP_BOTH);
        repeat (12) begin
            tick();
            upd_cnt += int'(value_upd);
        end
        btn_step = 1'b0;
        btn_load = 1'b0;
        repeat (12) begin
            tick();
            upd_cnt += int'(value_upd);
        end
        check($sformatf("vec%0d_value", idx), 32'(value), 32'(v.exp));
        check($sformatf("vec%0d_upd_count", idx), 32'(upd_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{OP_LOAD, 1'b0, 4'hF, 4'hF};
        vecs[1] = '{OP_STEP, 1'b1, 4'h0, 4'h0};  // 15 -> 0 wrap up
        vecs[2] = '{OP_STEP, 1'b0, 4'h0, 4'hF};  // 0 -> 15 wrap down
        vecs[3] = '{OP_STEP, 1'b0, 4'h0, 4'hE};
        vecs[4] = '{OP_LOAD, 1'b1, 4'hE, 4'hE};  // same value still pulses
        vecs[5] = '{OP_BOTH, 1'b1, 4'hA, 4'hA};  // load wins over step
        vecs[6] = '{OP_STEP, 1'b1, 4'h3, 4'hB};
        vecs[7] = '{OP_LOAD, 1'b0, 4'h0, 4'h0};
        vecs[8] = '{OP_STEP, 1'b0, 4'h7, 4'hF};

        rst_n    = 1'b0;
        btn_step = 1'b1;   // held through reset release
        btn_load = 1'b0;
        dir      = 1'b1;
        sw       = '0;
`ifdef AUTO_STEP_EN
        auto_en  = 1'b0;
`endif
        ticks(3);
        check("reset_value", 32'(value), 32'd0);
        check("reset_upd", 32'(value_upd), 32'd0);

        // Held button after reset: first step exactly 7 edges after release
        rst_n = 1'b1;
        ticks(7);
        check("t1_value_before", 32'(value), 32'd0);
        check("t1_upd_before", 32'(value_upd), 32'd0);
        tick();
        check("t1_value_step", 32'(value), 32'd1);
        check("t1_upd_pulse", 32'(value_upd), 32'd1);
        tick();
        check("t1_upd_single", 32'(value_upd), 32'd0);
        ticks(10);
        check("t1_value_held", 32'(value), 32'd1);
        btn_step = 1'b0;
        ticks(12);

        // Bounce 1,0,1,0 then stable: only the stable run counts
        foreach (vecs[i]) begin end
        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        btn_step = 1'b1;
        ticks(7);
        check("t2_value_before", 32'(value), 32'd1);
        tick();
        check("t2_value_step", 32'(value), 32'd2);
        check("t2_upd_pulse", 32'(value_upd), 32'd1);
        btn_step = 1'b0;
        ticks(12);

        for (int i = 0; i < 9; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Reset during RISE_WAIT with cnt=3, button kept high afterwards
        dir      = 1'b1;
        btn_step = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        tick();
        check("t5_value_reset", 32'(value), 32'd0);
        rst_n = 1'b1;
        ticks(7);
        check("t5_value_before", 32'(value), 32'd0);
        check("t5_upd_before", 32'(value_upd), 32'd0);
        tick();
        check("t5_value_step", 32'(value), 32'd1);
        check("t5_upd_pulse", 32'(value_upd), 32'd1);
        btn_step = 1'b0;
        ticks(12);

`ifdef AUTO_STEP_EN
        begin
            bit found;
            rst_n = 1'b0;
            tick();
            rst_n   = 1'b1;
            dir     = 1'b1;
            auto_en = 1'b1;
            ticks(7);
            check("t6_value_before", 32'(value), 32'd0);
            tick();
            check("t6_value_1", 32'(value), 32'd1);
            check("t6_upd_1", 32'(value_upd), 32'd1);
            ticks(8);
            check("t6_value_2", 32'(value), 32'd2);
            ticks(8);
            check("t6_value_3", 32'(value), 32'd3);
            ticks(3);
            sw       = 4'h5;
            btn_load = 1'b1;
            found    = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                tick();
                if (value_upd && value == 4'h5) found = 1'b1;
            end
            check("t6_load_seen", 32'(found), 32'd1);
            btn_load = 1'b0;
            ticks(7);
            check("t6_value_after_load", 32'(value), 32'd5);
            tick();
            check("t6_value_tick", 32'(value), 32'd6);
            check("t6_upd_tick", 32'(value_upd), 32'd1);
            auto_en = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
